// File: rtl/nco_i2s_serializer.sv
// I2S stereo serializer for NCO samples: sin -> left slot, cos -> right slot, MSB first, one-bit delay.
// Optional macro NCO_I2S_MUTE_EN adds a frame-aligned mute input that zeroes both captured samples.
module nco_i2s_serializer #(
   parameter int DATA_WIDTH = 12,
   parameter int SLOT_WIDTH = 16,
   parameter int BCLK_DIV   = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] sin_val,
   input  logic [DATA_WIDTH-1:0] cos_val,
`ifdef NCO_I2S_MUTE_EN
   input  logic                  mute,
`endif
   output logic                  bclk,
   output logic                  lrclk,
   output logic                  sdata,
   output logic                  sample_taken
);

   localparam int FRAME_BITS = 2 * SLOT_WIDTH;
   localparam int DIV_W      = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
   localparam int IDX_W      = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
   localparam int PAD_W      = SLOT_WIDTH - DATA_WIDTH;

   logic [DIV_W-1:0]      div_cnt_q, div_cnt_d;
   logic                  bclk_q, bclk_d;
   logic [IDX_W-1:0]      bit_idx_q, bit_idx_d;
   logic                  lrclk_q, lrclk_d;
   logic                  sdata_q, sdata_d;
   logic                  sample_q, sample_d;
   logic [FRAME_BITS-1:0] shift_q, shift_d;
   logic [DATA_WIDTH-1:0] sin_hold_q, sin_hold_d;
   logic [DATA_WIDTH-1:0] cos_hold_q, cos_hold_d;

   logic                  div_wrap, fall_tick, last_bit, capture, load, mute_w;
   logic [IDX_W-1:0]      bit_idx_nxt;
   logic [SLOT_WIDTH-1:0] sin_slot, cos_slot;
   logic [FRAME_BITS-1:0] frame_word;

`ifdef NCO_I2S_MUTE_EN
   assign mute_w = mute;
`else
   assign mute_w = 1'b0;
`endif

   assign div_wrap    = (div_cnt_q == DIV_W'(BCLK_DIV - 1));
   assign fall_tick   = div_wrap & bclk_q;
   assign last_bit    = (bit_idx_q == IDX_W'(FRAME_BITS - 1));
   assign bit_idx_nxt = last_bit ? '0 : bit_idx_q + IDX_W'(1);
   assign capture     = fall_tick & last_bit;
   assign load        = fall_tick & (bit_idx_q == '0);

   // Samples sit in the slot MSBs; zero-extend then shift the padding in below the LSB.
   assign sin_slot   = SLOT_WIDTH'(sin_hold_q) << PAD_W;
   assign cos_slot   = SLOT_WIDTH'(cos_hold_q) << PAD_W;
   assign frame_word = {sin_slot, cos_slot};

   always_comb begin
      div_cnt_d  = div_wrap ? '0 : div_cnt_q + DIV_W'(1);
      bclk_d     = div_wrap ? ~bclk_q : bclk_q;
      bit_idx_d  = bit_idx_q;
      lrclk_d    = lrclk_q;
      sdata_d    = sdata_q;
      shift_d    = shift_q;
      sample_d   = capture;
      sin_hold_d = sin_hold_q;
      cos_hold_d = cos_hold_q;

      if (fall_tick) begin
         bit_idx_d = bit_idx_nxt;
         lrclk_d   = (bit_idx_nxt >= IDX_W'(SLOT_WIDTH));
         // Entering bit 1 loads the frame captured at bit 0, giving the I2S one-bit delay.
         if (load) begin
            sdata_d = frame_word[FRAME_BITS-1];
            shift_d = frame_word << 1;
         end else begin
            sdata_d = shift_q[FRAME_BITS-1];
            shift_d = shift_q << 1;
         end
      end

      if (capture) begin
         sin_hold_d = mute_w ? '0 : sin_val;
         cos_hold_d = mute_w ? '0 : cos_val;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_cnt_q  <= '0;
         bclk_q     <= 1'b0;
         bit_idx_q  <= '0;
         lrclk_q    <= 1'b0;
         sdata_q    <= 1'b0;
         sample_q   <= 1'b0;
         shift_q    <= '0;
         sin_hold_q <= '0;
         cos_hold_q <= '0;
      end else begin
         div_cnt_q  <= div_cnt_d;
         bclk_q     <= bclk_d;
         bit_idx_q  <= bit_idx_d;
         lrclk_q    <= lrclk_d;
         sdata_q    <= sdata_d;
         sample_q   <= sample_d;
         shift_q    <= shift_d;
         sin_hold_q <= sin_hold_d;
         cos_hold_q <= cos_hold_d;
      end
   end

   assign bclk         = bclk_q;
   assign lrclk        = lrclk_q;
   assign sdata        = sdata_q;
   assign sample_taken = sample_q;

endmodule

// File: tb/tb_nco_i2s_serializer.sv
// Bench for nco_i2s_serializer: frame-level model checked every clk, plus directed decodes of I2S words.
// Build with NCO_I2S_MUTE_EN defined to also exercise the mute input.
module tb_nco_i2s_serializer;

   localparam int DW    = 12;
   localparam int SW    = 16;
   localparam int DIV   = 4;
   localparam int BCLKP = 2 * DIV;
   localparam int FRAME = 2 * SW * BCLKP;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [DW-1:0] sin_val = '0;
   logic [DW-1:0] cos_val = '0;
   logic          mute = 1'b0;
   logic          bclk, lrclk, sdata, sample_taken;

   int checks = 0;
   int errors = 0;

   nco_i2s_serializer #(.DATA_WIDTH(DW), .SLOT_WIDTH(SW), .BCLK_DIV(DIV)) dut (
      .clk          (clk),
      .rst          (rst),
      .sin_val      (sin_val),
      .cos_val      (cos_val),
`ifdef NCO_I2S_MUTE_EN
      .mute         (mute),
`endif
      .bclk         (bclk),
      .lrclk        (lrclk),
      .sdata        (sdata),
      .sample_taken (sample_taken)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (time %0t)", name, act, exp, $time);
      end
   endtask

   // Frame-level model: t = clk edges since reset release; f_cur is the word sent in the
   // current frame, f_prev the word whose LSB trails into bit 0.
   int          t = 0;
   logic [31:0] f_cur = '0;
   logic [31:0] f_prev = '0;
   logic        mute_eff;
`ifdef NCO_I2S_MUTE_EN
   assign mute_eff = mute;
`else
   assign mute_eff = 1'b0;
`endif

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         t      = 0;
         f_cur  = '0;
         f_prev = '0;
      end else begin
         t = t + 1;
         if (t % FRAME == 0) begin
            f_prev = f_cur;
            f_cur  = mute_eff ? 32'h0 : {sin_val, 4'h0, cos_val, 4'h0};
         end
      end
   end

   always @(negedge clk) begin
      int   b;
      logic e_bclk, e_lr, e_sd, e_st;
      if (rst) begin
         e_bclk = 1'b0; e_lr = 1'b0; e_sd = 1'b0; e_st = 1'b0;
      end else begin
         b      = (t / BCLKP) % (2 * SW);
         e_bclk = ((t / DIV) % 2) == 1;
         e_lr   = (b >= SW);
         e_st   = (t > 0) && (t % FRAME == 0);
         e_sd   = (b == 0) ? f_prev[0] : f_cur[2*SW - b];
      end
      chk("model_bclk", 32'(bclk), 32'(e_bclk));
      chk("model_lrclk", 32'(lrclk), 32'(e_lr));
      chk("model_sdata", 32'(sdata), 32'(e_sd));
      chk("model_sample_taken", 32'(sample_taken), 32'(e_st));
   end

   // Called right after release on a negedge: i counts clk edges since release.
   task automatic check_startup(input string tag);
      int   first_rise, second_rise, st1, st2;
      logic pb;
      first_rise = -1; second_rise = -1; st1 = -1; st2 = -1;
      pb = bclk;
      for (int i = 1; i <= 2 * FRAME + 8; i++) begin
         @(negedge clk);
         if (!pb && bclk) begin
            if (first_rise < 0) first_rise = i;
            else if (second_rise < 0) second_rise = i;
         end
         pb = bclk;
         if (sample_taken) begin
            if (st1 < 0) st1 = i;
            else if (st2 < 0) st2 = i;
         end
         if (i == FRAME - 1) chk({tag, "_lrclk_before_capture"}, 32'(lrclk), 32'd1);
         if (i == FRAME)     chk({tag, "_lrclk_at_capture"}, 32'(lrclk), 32'd0);
         if (i == FRAME + 1) chk({tag, "_sample_taken_width"}, 32'(sample_taken), 32'd0);
      end
      chk({tag, "_first_bclk_rise"}, 32'(first_rise), 32'd4);
      chk({tag, "_second_bclk_rise"}, 32'(second_rise), 32'd12);
      chk({tag, "_first_sample_taken"}, 32'(st1), 32'd256);
      chk({tag, "_second_sample_taken"}, 32'(st2), 32'd512);
   endtask

   // Wait for an lrclk 1->0 edge, then collect the 32 bits on bclk rises 1..32.
   task automatic decode(output logic [15:0] l, output logic [15:0] r);
      logic        prev_lr, prev_b;
      logic [31:0] w;
      int          n, rises;
      bit          got;
      prev_lr = lrclk; n = 0; got = 0; w = '0; rises = 0;
      while (!got && n < 3 * FRAME) begin
         @(negedge clk);
         n++;
         if (prev_lr && !lrclk) got = 1;
         prev_lr = lrclk;
      end
      if (!got) begin
         chk("decode_lrclk_timeout", 32'(n), 32'(0));
      end else begin
         prev_b = bclk; n = 0;
         while (rises < 33 && n < 2 * FRAME) begin
            @(negedge clk);
            n++;
            if (!prev_b && bclk) begin
               if (rises > 0) w = {w[30:0], sdata};
               rises++;
            end
            prev_b = bclk;
         end
         if (rises < 33) chk("decode_bclk_timeout", 32'(rises), 32'd33);
      end
      l = w[31:16];
      r = w[15:0];
   endtask

   task automatic wait_st();
      int n;
      n = 0;
      while (!sample_taken && n < 2 * FRAME) begin
         @(negedge clk);
         n++;
      end
      if (!sample_taken) chk("sample_taken_timeout", 32'(n), 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] l, r;
      int          n;
      #1 rst = 1'b1;
      repeat (3) @(negedge clk);
      sin_val = 12'h7FF;
      cos_val = 12'h800;
      rst = 1'b0;
      check_startup("boot");

      decode(l, r);
      chk("const_left", 32'(l), 32'h7FF0);
      chk("const_right", 32'(r), 32'h8000);

      // Capture 0x123, then change to 0x456 well inside the left slot.
      sin_val = 12'h123;
      fork
         decode(l, r);
         begin
            wait_st();
            repeat (40) @(negedge clk);
            sin_val = 12'h456;
         end
      join
      chk("midframe_left_old", 32'(l), 32'h1230);
      chk("midframe_right_old", 32'(r), 32'h8000);
      decode(l, r);
      chk("midframe_left_new", 32'(l), 32'h4560);
      chk("midframe_right_new", 32'(r), 32'h8000);

      // Asynchronous reset in the right slot.
      sin_val = 12'h7FF;
      n = 0;
      while (!lrclk && n < 2 * FRAME) begin
         @(negedge clk);
         n++;
      end
      repeat (20) @(negedge clk);
      chk("pre_reset_lrclk", 32'(lrclk), 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_bclk", 32'(bclk), 32'd0);
      chk("async_rst_lrclk", 32'(lrclk), 32'd0);
      chk("async_rst_sdata", 32'(sdata), 32'd0);
      chk("async_rst_sample_taken", 32'(sample_taken), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      check_startup("rerun");
      decode(l, r);
      chk("post_reset_left", 32'(l), 32'h7FF0);
      chk("post_reset_right", 32'(r), 32'h8000);

`ifdef NCO_I2S_MUTE_EN
      fork
         decode(l, r);
         begin
            wait_st();
            repeat (40) @(negedge clk);
            mute = 1'b1;
         end
      join
      chk("mute_raise_left", 32'(l), 32'h7FF0);
      chk("mute_raise_right", 32'(r), 32'h8000);
      fork
         decode(l, r);
         begin
            wait_st();
            repeat (40) @(negedge clk);
            mute = 1'b0;
         end
      join
      chk("muted_left", 32'(l), 32'h0000);
      chk("muted_right", 32'(r), 32'h0000);
      decode(l, r);
      chk("unmute_left", 32'(l), 32'h7FF0);
      chk("unmute_right", 32'(r), 32'h8000);
`endif

      repeat (4) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
